// File: rtl/alu_ctrl_muldiv_seq_if.sv
// EX-stage bundle between the pipeline and the ALU control / RV32M sequencer:
// decode fields, operands, control outputs and multiply/divide result.
interface alu_ctrl_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp;
    logic [2:0]      function3;
    logic            funct7_5;
    logic            funct7_0;
    logic            issue;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      ALU_sel;
    logic            illegal;
    logic            md_sel;
    logic            stall;
    logic [XLEN-1:0] md_result;
    logic            md_done;

    modport master (
        output ALUOp, function3, funct7_5, funct7_0, issue, flush, op_a, op_b,
        input  ALU_sel, illegal, md_sel, stall, md_result, md_done
    );

    modport slave (
        input  ALUOp, function3, funct7_5, funct7_0, issue, flush, op_a, op_b,
        output ALU_sel, illegal, md_sel, stall, md_result, md_done
    );
endinterface

// File: rtl/alu_ctrl_muldiv_seq.sv
// EX-stage ALU control decode plus an iterative RV32M multiply/divide
// sequencer that stalls the pipeline for one bit per cycle.
module alu_ctrl_muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic                 clk,
    input logic                 rst,
    alu_ctrl_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   ITER    = CW'(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_opB;
    logic              r_negHi;
    logic              r_negRem;
    logic [1:0]        r_f3;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    logic [3:0]        w_aluSel;
    logic              w_illegal;
    logic              w_mOp;

    always_comb begin
        w_aluSel  = 4'b0010;
        w_illegal = 1'b0;
        w_mOp     = 1'b0;
        case (bus.ALUOp)
            2'b00: w_aluSel = 4'b0010;
            2'b01: begin
                case (bus.function3)
                    3'b000, 3'b001: w_aluSel = 4'b0110;
                    3'b100, 3'b101: w_aluSel = 4'b1010;
                    3'b110, 3'b111: w_aluSel = 4'b1011;
                    default:        w_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                if (bus.funct7_0) begin
                    w_mOp = 1'b1;
                end else if (bus.funct7_5 && bus.function3 != 3'b000 && bus.function3 != 3'b101) begin
                    w_illegal = 1'b1;
                end else begin
                    case (bus.function3)
                        3'b000:  w_aluSel = bus.funct7_5 ? 4'b0110 : 4'b0010;
                        3'b001:  w_aluSel = 4'b0111;
                        3'b010:  w_aluSel = 4'b1010;
                        3'b011:  w_aluSel = 4'b1011;
                        3'b100:  w_aluSel = 4'b0100;
                        3'b101:  w_aluSel = bus.funct7_5 ? 4'b1001 : 4'b1000;
                        3'b110:  w_aluSel = 4'b0001;
                        default: w_aluSel = 4'b0000;
                    endcase
                end
            end
            default: begin
                // ADDI etc. carry immediate bits in instr[30]; only shifts look at it
                case (bus.function3)
                    3'b000:  w_aluSel = 4'b0010;
                    3'b001:  w_aluSel = 4'b0111;
                    3'b010:  w_aluSel = 4'b1010;
                    3'b011:  w_aluSel = 4'b1011;
                    3'b100:  w_aluSel = 4'b0100;
                    3'b101:  w_aluSel = bus.funct7_5 ? 4'b1001 : 4'b1000;
                    3'b110:  w_aluSel = 4'b0001;
                    default: w_aluSel = 4'b0000;
                endcase
            end
        endcase
    end

    logic            w_divSigned;
    logic            w_aNeg;
    logic            w_bNeg;
    logic [XLEN-1:0] w_absA;
    logic [XLEN-1:0] w_absB;
    logic            w_divOvf;

    // Only MULHU and the unsigned divides treat op_a as unsigned; op_b is signed for MUL/MULH only
    assign w_divSigned = ~bus.function3[0];
    assign w_aNeg  = bus.op_a[XLEN-1] & (bus.function3[2] ? w_divSigned : (bus.function3 != 3'b011));
    assign w_bNeg  = bus.op_b[XLEN-1] & (bus.function3[2] ? w_divSigned : (bus.function3[2:1] == 2'b00));
    assign w_absA  = w_aNeg ? -bus.op_a : bus.op_a;
    assign w_absB  = w_bNeg ? -bus.op_b : bus.op_b;
    assign w_divOvf = w_divSigned && bus.op_a == MIN_NEG && bus.op_b == {XLEN{1'b1}};

    logic [XLEN:0]     w_addSum;
    logic [2*XLEN-1:0] w_mulNext;
    logic [2*XLEN-1:0] w_mulFinal;
    logic [XLEN-1:0]   w_mulResult;

    assign w_addSum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opB : {XLEN{1'b0}})};
    assign w_mulNext   = {w_addSum, r_prod[XLEN-1:1]};
    assign w_mulFinal  = r_negHi ? -w_mulNext : w_mulNext;
    assign w_mulResult = (r_f3 == 2'b00) ? w_mulFinal[XLEN-1:0] : w_mulFinal[2*XLEN-1:XLEN];

    logic [XLEN:0]   w_divShift;
    logic [XLEN:0]   w_divDiff;
    logic            w_divFit;
    logic [XLEN-1:0] w_divRem;
    logic [XLEN-1:0] w_divQuo;
    logic [XLEN-1:0] w_divResult;

    // r_prod holds {partial remainder, dividend/quotient shift register} while dividing
    assign w_divShift  = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_divDiff   = w_divShift - {1'b0, r_opB};
    assign w_divFit    = ~w_divDiff[XLEN];
    assign w_divRem    = w_divFit ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0];
    assign w_divQuo    = {r_prod[XLEN-2:0], w_divFit};
    assign w_divResult = r_f3[1] ? (r_negRem ? -w_divRem : w_divRem)
                                 : (r_negHi ? -w_divQuo : w_divQuo);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_prod   <= '0;
            r_opB    <= '0;
            r_negHi  <= 1'b0;
            r_negRem <= 1'b0;
            r_f3     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.issue && w_mOp) begin
                        r_prod   <= {{XLEN{1'b0}}, w_absA};
                        r_opB    <= w_absB;
                        r_negHi  <= w_aNeg ^ w_bNeg;
                        r_negRem <= w_aNeg;
                        r_f3     <= bus.function3[1:0];
                        if (!bus.function3[2]) begin
                            r_state <= MUL;
                            r_count <= ITER;
                        end else if (bus.op_b == '0) begin
                            r_state  <= DONE;
                            r_result <= bus.function3[1] ? bus.op_a : {XLEN{1'b1}};
                            r_done   <= 1'b1;
                        end else if (w_divOvf) begin
                            r_state  <= DONE;
                            r_result <= bus.function3[1] ? {XLEN{1'b0}} : bus.op_a;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= DIV;
                            r_count <= ITER;
                        end
                    end
                end
                MUL: begin
                    r_prod  <= w_mulNext;
                    r_count <= r_count - 1'b1;
                    if (r_count == LAST) begin
                        r_state  <= DONE;
                        r_result <= w_mulResult;
                        r_done   <= 1'b1;
                    end
                end
                DIV: begin
                    r_prod  <= {w_divRem, w_divQuo};
                    r_count <= r_count - 1'b1;
                    if (r_count == LAST) begin
                        r_state  <= DONE;
                        r_result <= w_divResult;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ALU_sel   = w_aluSel;
    assign bus.illegal   = w_illegal;
    assign bus.md_sel    = w_mOp;
    assign bus.stall     = (r_state == IDLE && bus.issue && w_mOp) || r_state == MUL || r_state == DIV;
    assign bus.md_result = r_result;
    assign bus.md_done   = r_done;
endmodule

// File: doc/alu_ctrl_muldiv_seq.md
# alu_ctrl_muldiv_seq

Parametrised next-generation EX-stage ALU control for the pipelined RV32 core. Decodes ALUOp/function3/funct7 bits into the existing 4-bit ALU_sel encoding, adds branch-specific compare selection, and flags illegal encodings. Adds RV32M support through an iterative multiply/divide sequencer that stalls the pipeline until the result is ready.

## Interface
- XLEN, 32: operand/result width; iteration count of the multiply/divide sequencer.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- function3  in  3  instruction funct3.
- funct7_5  in  1  instr[30]: SUB/SRA/SRAI selector.
- funct7_0  in  1  instr[25]: M-extension selector, R-type only.
- issue  in  1  EX-stage instruction valid this cycle.
- flush  in  1  kill the EX-stage instruction.
- op_a, op_b  in  XLEN  forwarded rs1/rs2 values.
- ALU_sel  out  4  ALU operation code.
- illegal  out  1  encoding not recognised.
- md_sel  out  1  EX result mux takes md_result.
- stall  out  1  hold IF/ID/EX.
- md_result  out  XLEN  multiply/divide result.
- md_done  out  1  one-cycle completion pulse.

## Operation
- ALU_sel codes: AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110, SLL 0111, SRL 1000, SRA 1001, SLT 1010, SLTU 1011.
- ALUOp 00 -> ADD.
- ALUOp 01 (branch): funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
- ALUOp 10 with funct7_0=0: the R-type table (ADD/SUB selected by funct7_5; SRL/SRA selected by funct7_5). funct7_5=1 with any funct3 other than 000/101 -> illegal.
- ALUOp 10 with funct7_0=1: M-op, md_sel=1; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ALUOp 11: the I-type table; funct3 101 uses funct7_5 to select SRLI or SRAI.
- Illegal encodings drive ALU_sel=0010 and illegal=1. Decode is purely combinational, with no latches.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on issue && M-op && !flush, latch op_a, op_b and funct3, then branch by op:
    - Multiply op -> MUL, counter=XLEN.
    - Divide op with op_b==0 -> DONE; quotient all-ones, remainder = op_a.
    - DIV/REM with op_a = most-negative value and op_b = -1 -> DONE; quotient = op_a, remainder = 0.
    - Any other divide op -> DIV, counter=XLEN.
  - MUL: shift-add of 2·XLEN product on operand magnitudes, one bit per cycle. Sign correction per op signedness (MULHSU: op_a signed, op_b unsigned). MUL returns the low half; the MULH variants return the high half.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. Quotient is negated when operand signs differ (signed ops). Remainder takes the dividend's sign. DIVU/REMU are unsigned.
  - MUL/DIV exit to DONE when the counter reaches 0.
  - DONE: md_result registered, md_done=1, then unconditionally -> IDLE. The held instruction advances this cycle and must not re-trigger.
- stall = (IDLE && issue && M-op) || MUL || DIV. stall is 0 in DONE.
- md_result holds its value until the next completion.

## Timing
- Reset (rst=1 at an edge): state IDLE, counter 0, md_result 0, md_done 0. stall, ALU_sel and illegal follow the combinational inputs.
- Multiply, and non-special divide: issue in cycle 0; stall high cycles 0..XLEN (XLEN+1 cycles); DONE and md_done in cycle XLEN+1.
- Special-case divide: stall high in cycle 0 only; md_done in cycle 1.
- Non-M ops never stall and never touch the FSM.
- flush or rst in any state: IDLE at the next edge; no md_done pulse; md_result unchanged (rst clears it).
- Priority: rst > flush > issue.
- flush concurrent with issue in IDLE: no start. stall still follows its combinational equation for that cycle.
- The counter width is clog2(XLEN+1). XLEN is not restricted to 32.

## Test plan
- Decode sweep: R funct3=000, funct7_5=1 -> 0110; branch funct3=110 -> 1011; I funct3=101, funct7_5=1 -> 1001; branch funct3=010 -> illegal=1, ALU_sel=0010.
- MUL 7 × -3 -> md_result 0xFFFFFFEB; stall high exactly 33 cycles; md_done single pulse in cycle 33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; all with a one-cycle stall.
- flush at cycle 10 of a DIV -> IDLE next edge, stall 0, no md_done, md_result keeps its old value. Then an immediate new MUL completes correctly.
